bambu_mem_responder: RTL and testbench

- Two-channel, byte-addressed external memory responder for HLS-generated accelerators.
- Answers the accelerator's master-side memory requests (oe/we/addr/wdata/size per channel) with fixed read and write latencies.
- Mirrors the timing the simulation environment models: 2-cycle read, 1-cycle write.
- Sits beside the accelerator top in the simulation and FPGA wrappers. Replaces the testbench byte array as the far end of the memory protocol.

---
 rtl/bambu_mem_responder_if.sv | 25 ++
 rtl/bambu_mem_responder.sv | 165 ++++++++++++++++
 tb/tb_bambu_mem_responder.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/bambu_mem_responder_if.sv
// Two-channel memory request/response bundle between an HLS accelerator (master)
// and its external memory responder (slave).
interface bambu_mem_responder_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 64,
  parameter int SIZE_W = 7
);
  logic [1:0]          M_oe_ram;
  logic [1:0]          M_we_ram;
  logic [2*ADDR_W-1:0] M_addr_ram;
  logic [2*DATA_W-1:0] M_Wdata_ram;
  logic [2*SIZE_W-1:0] M_data_ram_size;
  logic [2*DATA_W-1:0] M_Rdata_ram;
  logic [1:0]          M_DataRdy;

  modport master (
    output M_oe_ram, M_we_ram, M_addr_ram, M_Wdata_ram, M_data_ram_size,
    input  M_Rdata_ram, M_DataRdy
  );

  modport slave (
    input  M_oe_ram, M_we_ram, M_addr_ram, M_Wdata_ram, M_data_ram_size,
    output M_Rdata_ram, M_DataRdy
  );
endinterface

// File: rtl/bambu_mem_responder.sv
// Byte-addressed two-channel memory responder with fixed read/write latencies;
// each channel runs its own IDLE/BUSY FSM over a shared backing byte array.
module bambu_mem_responder #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 64,
  parameter int SIZE_W      = 7,
  parameter int MEM_BYTES   = 32,
  parameter int BASE_ADDR   = 0,
  parameter int READ_DELAY  = 2,
  parameter int WRITE_DELAY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  bambu_mem_responder_if.slave  bus,
  output logic                  err_flag
);
  localparam int MAX_DELAY = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
  localparam int CNT_W     = $clog2(MAX_DELAY + 1);
  localparam int MEM_AW    = $clog2(MEM_BYTES);
  localparam int NB        = DATA_W / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  logic [7:0]                       mem_reg [MEM_BYTES];
  logic [1:0][MEM_BYTES-1:0]        ch_we;
  logic [1:0][MEM_BYTES-1:0][7:0]   ch_wb;
  logic [1:0]                       ch_err;
  logic                             err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      state_t                         state_reg, state_next;
      logic [CNT_W-1:0]               cnt_reg, cnt_next;
      logic [ADDR_W-1:0]              addr_reg;
      logic [DATA_W-1:0]              wdata_reg;
      logic [SIZE_W-1:0]              size_reg;
      logic                           wr_reg;
      logic                           both_reg;
      logic                           rdy_reg;
      logic [DATA_W-1:0]              rdata_reg;
      logic                           oe, we, accept, done, in_range;
      int                             off, nbytes;
      logic [DATA_W-1:0]              rd_val;
      logic [MEM_BYTES-1:0]           we_map;
      logic [MEM_BYTES-1:0][7:0]      wb_map;

      assign oe = bus.M_oe_ram[gi];
      assign we = bus.M_we_ram[gi];

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        done       = 1'b0;
        case (state_reg)
          IDLE: begin
            if (oe || we) begin
              accept     = 1'b1;
              state_next = BUSY;
              // oe+we together is timed as a write
              cnt_next   = we ? CNT_W'(WRITE_DELAY - 1) : CNT_W'(READ_DELAY - 1);
            end
          end
          BUSY: begin
            if (cnt_reg == '0) begin
              done       = 1'b1;
              state_next = IDLE;
            end else begin
              cnt_next = cnt_reg - 1'b1;
            end
          end
        endcase
      end

      always_comb begin
        case (size_reg)
          SIZE_W'(8):  nbytes = 1;
          SIZE_W'(16): nbytes = 2;
          SIZE_W'(32): nbytes = 4;
          SIZE_W'(64): nbytes = 8;
          default:     nbytes = 0;
        endcase
        off      = int'(addr_reg) - BASE_ADDR;
        in_range = (nbytes != 0) && (nbytes * 8 <= DATA_W) &&
                   (off >= 0) && (off + nbytes <= MEM_BYTES);
        rd_val   = '0;
        we_map   = '0;
        wb_map   = '0;
        // Reads sample mem_reg before this edge's writes land: read-before-write
        for (int k = 0; k < NB; k++) begin
          if (in_range && k < nbytes) begin
            rd_val[8*k +: 8] = mem_reg[MEM_AW'(off + k)];
            if (done && wr_reg && !both_reg) begin
              we_map[MEM_AW'(off + k)] = 1'b1;
              wb_map[MEM_AW'(off + k)] = wdata_reg[8*k +: 8];
            end
          end
        end
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          addr_reg  <= '0;
          wdata_reg <= '0;
          size_reg  <= '0;
          wr_reg    <= 1'b0;
          both_reg  <= 1'b0;
          rdy_reg   <= 1'b0;
          rdata_reg <= '0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          rdy_reg   <= done;
          if (accept) begin
            addr_reg  <= bus.M_addr_ram[gi*ADDR_W +: ADDR_W];
            wdata_reg <= bus.M_Wdata_ram[gi*DATA_W +: DATA_W];
            size_reg  <= bus.M_data_ram_size[gi*SIZE_W +: SIZE_W];
            wr_reg    <= we;
            both_reg  <= oe && we;
          end
          if (done && !wr_reg) begin
            rdata_reg <= rd_val;
          end
        end
      end

      assign ch_we[gi]  = we_map;
      assign ch_wb[gi]  = wb_map;
      assign ch_err[gi] = done && (both_reg || !in_range);

      assign bus.M_Rdata_ram[gi*DATA_W +: DATA_W] = rdata_reg;
      assign bus.M_DataRdy[gi]                    = rdy_reg;
    end
  endgenerate

  // Channel 1 takes priority when both channels commit the same byte
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem_reg[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < MEM_BYTES; i++) begin
        if (ch_we[1][i]) begin
          mem_reg[i] <= ch_wb[1][i];
        end else if (ch_we[0][i]) begin
          mem_reg[i] <= ch_wb[0][i];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (|ch_err) begin
      err_reg <= 1'b1;
    end
  end

  assign err_flag = err_reg;
endmodule

// File: tb/tb_bambu_mem_responder.sv
// Directed scoreboard bench for bambu_mem_responder: drivers queue expected completions,
// a negedge monitor pops and checks them whenever a channel pulses DataRdy.
module tb_bambu_mem_responder;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 64;
  localparam int SIZE_W = 7;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic err_flag;

  bambu_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W)) bus ();

  bambu_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W),
    .MEM_BYTES(32), .BASE_ADDR(0), .READ_DELAY(2), .WRITE_DELAY(1)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .err_flag (err_flag)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          due;
    string       name;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          compared   = 0;
  int          mismatched = 0;
  logic [63:0] last_rd [2];

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic pop_check(int c);
    exp_t e;
    if ((c == 0 && q0.size() == 0) || (c == 1 && q1.size() == 0)) begin
      compared++;
      mismatched++;
      $display("FAIL ch%0d unexpected DataRdy: actual=pulse at cycle %0d required=no pulse", c, cyc);
      return;
    end
    if (c == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    check($sformatf("ch%0d %s cycle", c, e.name), 64'(cyc), 64'(e.due));
    check($sformatf("ch%0d %s rdata", c, e.name), bus.M_Rdata_ram[c*DATA_W +: DATA_W], e.rdata);
    check($sformatf("ch%0d %s err", c, e.name), 64'(err_flag), 64'(e.err));
    $display("ch%0d %s done at cycle %0d rdata=%h err=%0b", c, e.name, cyc,
             bus.M_Rdata_ram[c*DATA_W +: DATA_W], err_flag);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      for (int c = 0; c < 2; c++) begin
        if (bus.M_DataRdy[c]) pop_check(c);
      end
    end
  end

  // Drive a request (caller is between edges), queue its expectation, hold until DataRdy.
  task automatic issue(int c, logic oe, logic we, int addr, int size, logic [63:0] wdata,
                       logic [63:0] exp_rd, logic exp_err, string name);
    exp_t e;
    int   k;
    bus.M_oe_ram[c]                             = oe;
    bus.M_we_ram[c]                             = we;
    bus.M_addr_ram[c*ADDR_W +: ADDR_W]          = ADDR_W'(addr);
    bus.M_Wdata_ram[c*DATA_W +: DATA_W]         = wdata;
    bus.M_data_ram_size[c*SIZE_W +: SIZE_W]     = SIZE_W'(size);
    @(posedge clock);
    #1;
    e.due  = cyc + (we ? 1 : 2);
    e.err  = exp_err;
    e.name = name;
    if (!we) last_rd[c] = exp_rd;
    e.rdata = last_rd[c];
    if (c == 0) q0.push_back(e);
    else        q1.push_back(e);
    for (k = 0; k < 20; k++) begin
      @(negedge clock);
      if (bus.M_DataRdy[c]) break;
    end
    compared++;
    if (k == 20) begin
      mismatched++;
      $display("FAIL ch%0d %s timeout: actual=no DataRdy in 20 cycles required=DataRdy", c, name);
    end
  endtask

  task automatic idle(int c);
    bus.M_oe_ram[c] = 1'b0;
    bus.M_we_ram[c] = 1'b0;
  endtask

  initial begin
    bus.M_oe_ram        = '0;
    bus.M_we_ram        = '0;
    bus.M_addr_ram      = '0;
    bus.M_Wdata_ram     = '0;
    bus.M_data_ram_size = '0;
    last_rd[0]          = '0;
    last_rd[1]          = '0;

    #12;
    check("reset DataRdy", 64'(bus.M_DataRdy), 64'h0);
    check("reset Rdata lo", bus.M_Rdata_ram[63:0], 64'h0);
    check("reset Rdata hi", bus.M_Rdata_ram[127:64], 64'h0);
    check("reset err_flag", 64'(err_flag), 64'h0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Basic write/read and byte ordering
    issue(0, 1'b0, 1'b1, 4, 32, 64'hDEADBEEF, 64'h0, 1'b0, "wr4_32");
    idle(0);
    @(negedge clock);
    issue(0, 1'b1, 1'b0, 4, 32, 64'h0, 64'h00000000DEADBEEF, 1'b0, "rd4_32");
    idle(0);
    issue(1, 1'b1, 1'b0, 5, 8, 64'h0, 64'hBE, 1'b0, "rd5_8");
    idle(1);
    @(negedge clock);
    issue(1, 1'b1, 1'b0, 6, 16, 64'h0, 64'hDEAD, 1'b0, "rd6_16");
    idle(1);
    @(negedge clock);

    // Same-edge write/write: channel 1 wins
    fork
      issue(0, 1'b0, 1'b1, 0, 8, 64'h11, 64'h0, 1'b0, "wr0_11");
      issue(1, 1'b0, 1'b1, 0, 8, 64'h22, 64'h0, 1'b0, "wr0_22");
    join
    idle(0);
    idle(1);
    @(negedge clock);
    issue(0, 1'b1, 1'b0, 0, 8, 64'h0, 64'h22, 1'b0, "rd0_after_collision");
    idle(0);
    @(negedge clock);

    // Same-edge read/write: read sees the old byte
    fork
      issue(0, 1'b1, 1'b0, 0, 8, 64'h0, 64'h22, 1'b0, "rd0_rbw");
      begin
        @(negedge clock);
        issue(1, 1'b0, 1'b1, 0, 8, 64'h33, 64'h0, 1'b0, "wr0_33");
      end
    join
    idle(0);
    idle(1);
    @(negedge clock);

    // Back-to-back reads, each reissued during the DataRdy cycle
    issue(0, 1'b1, 1'b0, 4, 32, 64'h0, 64'h00000000DEADBEEF, 1'b0, "b2b_1");
    issue(0, 1'b1, 1'b0, 0, 8,  64'h0, 64'h33, 1'b0, "b2b_2");
    issue(0, 1'b1, 1'b0, 5, 16, 64'h0, 64'hADBE, 1'b0, "b2b_3");
    issue(0, 1'b1, 1'b0, 0, 64, 64'h0, 64'hDEADBEEF00000033, 1'b0, "b2b_4");
    idle(0);
    @(negedge clock);

    // Top boundary: last four bytes are legal
    issue(1, 1'b0, 1'b1, 28, 32, 64'h01020304, 64'h0, 1'b0, "wr28_32");
    idle(1);
    @(negedge clock);
    issue(1, 1'b1, 1'b0, 28, 32, 64'h0, 64'h01020304, 1'b0, "rd28_32");
    idle(1);
    @(negedge clock);

    // Error cases
    issue(1, 1'b1, 1'b0, 30, 32, 64'h0, 64'h0, 1'b1, "rd30_oor");
    idle(1);
    @(negedge clock);
    issue(0, 1'b0, 1'b1, 8, 24, 64'hFFFFFF, 64'h0, 1'b1, "wr8_size24");
    idle(0);
    @(negedge clock);
    issue(0, 1'b1, 1'b0, 8, 32, 64'h0, 64'h0, 1'b1, "rd8_unchanged");
    idle(0);
    @(negedge clock);
    issue(1, 1'b1, 1'b1, 12, 8, 64'hAA, 64'h0, 1'b1, "oe_we_12");
    idle(1);
    @(negedge clock);
    issue(1, 1'b1, 1'b0, 12, 8, 64'h0, 64'h0, 1'b1, "rd12_unchanged");
    idle(1);
    @(negedge clock);
    issue(1, 1'b1, 1'b0, 4, 32, 64'h0, 64'h00000000DEADBEEF, 1'b1, "rd4_pre_reset");
    idle(1);
    @(negedge clock);

    // Reset one cycle after a read is accepted
    bus.M_oe_ram[0]                 = 1'b1;
    bus.M_addr_ram[0 +: ADDR_W]     = ADDR_W'(4);
    bus.M_data_ram_size[0 +: SIZE_W] = SIZE_W'(32);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("async reset DataRdy", 64'(bus.M_DataRdy), 64'h0);
    check("async reset Rdata lo", bus.M_Rdata_ram[63:0], 64'h0);
    check("async reset Rdata hi", bus.M_Rdata_ram[127:64], 64'h0);
    check("async reset err_flag", 64'(err_flag), 64'h0);
    idle(0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    issue(0, 1'b1, 1'b0, 4, 32, 64'h0, 64'h0, 1'b0, "rd4_after_reset");
    idle(0);
    issue(1, 1'b1, 1'b0, 28, 32, 64'h0, 64'h0, 1'b0, "rd28_after_reset");
    idle(1);
    repeat (4) @(negedge clock);

    check("ch0 pending expectations", 64'(q0.size()), 64'h0);
    check("ch1 pending expectations", 64'(q1.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
